// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and controller state encoding
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   localparam int FRAME_BITS = 32;
   localparam int DATA_BITS  = 16;

   // Command bytes understood by spi_slave_inf
   localparam logic [7:0] WRITE_CMD = 8'h01;
   localparam logic [7:0] READ_CMD  = 8'h02;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host request/response port of the SPI master controller
interface spi_master_ctrl_if;
   import spi_pkg::*;

   logic                 req_valid_i;
   logic                 req_ready_o;
   logic                 req_write_i;
   logic [7:0]           req_addr_i;
   logic [DATA_BITS-1:0] req_wdata_i;
   logic                 rsp_valid_o;
   logic [DATA_BITS-1:0] rsp_rdata_o;
   logic                 busy_o;

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
   );

   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
   );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - sclk half-period divider; high phase first, cleared while disabled
module spi_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sclk_o,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic half_end_o
);

   localparam int              HW      = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0]   HC_LAST = HW'(CLK_DIV - 1);

   logic [HW-1:0] hc_q, hc_d;
   logic          ph_q, ph_d;
   logic          hc_last;

   always_comb begin
      hc_last = (hc_q == HC_LAST);
      hc_d    = hc_q;
      ph_d    = ph_q;
      if (!en) begin
         hc_d = '0;
         ph_d = 1'b0;
      end else if (hc_last) begin
         hc_d = '0;
         ph_d = ~ph_q;
      end else begin
         hc_d = hc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q <= '0;
         ph_q <= 1'b0;
      end else begin
         hc_q <= hc_d;
         ph_q <= ph_d;
      end
   end

   // rise: first cycle of a high phase; fall: last high cycle, sclk drops at its end
   assign sclk_o      = en & ~ph_q;
   assign sclk_rise_o = en & ~ph_q & (hc_q == '0);
   assign sclk_fall_o = en & ~ph_q & hc_last;
   assign half_end_o  = en & hc_last;

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - one cmd/addr/data SPI frame per accepted host request
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter logic [7:0] cWriteCmd = WRITE_CMD,
   parameter logic [7:0] cReadCmd  = READ_CMD,
   parameter int         CLK_DIV   = 2,
   parameter int         CS_SETUP  = 2,
   parameter int         CS_HOLD   = 2,
   parameter int         CS_GAP    = 4
) (
   input  logic               spi_refclk_i,
   input  logic               spi_resetn_i,
   spi_master_ctrl_if.slave   host,
   output logic               spi_csb_o,
   output logic               spi_clk_o,
   output logic               spi_sdo_o,
   input  logic               spi_sdi_i
);

   localparam int CMAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CMAX  = (CMAX0 > CS_GAP) ? CMAX0 : CS_GAP;
   localparam int CW    = $clog2(CMAX + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

   localparam logic [2:0] S_IDLE  = 3'(IDLE);
   localparam logic [2:0] S_SETUP = 3'(SETUP);
   localparam logic [2:0] S_SHIFT = 3'(SHIFT);
   localparam logic [2:0] S_HOLD  = 3'(HOLD);
   localparam logic [2:0] S_GAP   = 3'(GAP);

   logic [2:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [5:0]            edge_cnt_q, edge_cnt_d;
   logic [FRAME_BITS-1:0] tx_q, tx_d;
   logic [DATA_BITS-1:0]  rx_q, rx_d;
   logic                  wr_q, wr_d;
   logic                  ready_q, ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_BITS-1:0]  rsp_rdata_q, rsp_rdata_d;

   logic sclk, sclk_rise, sclk_fall, half_end, accept;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk         (spi_refclk_i),
      .rst_n       (spi_resetn_i),
      .en          (state_q == S_SHIFT),
      .sclk_o      (sclk),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall),
      .half_end_o  (half_end)
   );

   assign accept = host.req_valid_i & ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      edge_cnt_d  = edge_cnt_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      wr_d        = wr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               wr_d    = host.req_write_i;
               tx_d    = {(host.req_write_i ? cWriteCmd : cReadCmd),
                          host.req_addr_i, host.req_wdata_i};
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            // Upper half of the edge count covers the 16 data bits
            if (sclk_rise && edge_cnt_q[5])
               rx_d = {rx_q[DATA_BITS-2:0], spi_sdi_i};
            if (sclk_fall)
               tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            if (half_end) begin
               edge_cnt_d = edge_cnt_q + 1'b1;
               if (edge_cnt_q == 6'd63)
                  state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d     = S_GAP;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = wr_q ? '0 : rx_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge spi_refclk_i or negedge spi_resetn_i) begin
      if (!spi_resetn_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         edge_cnt_q  <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         wr_q        <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         wr_q        <= wr_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Pins decode straight from state so an async reset idles them immediately
   assign spi_csb_o = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
   assign spi_clk_o = sclk;
   assign spi_sdo_o = tx_q[FRAME_BITS-1] & ((state_q == S_SETUP) || (state_q == S_SHIFT));

   assign host.req_ready_o = ready_q;
   assign host.rsp_valid_o = rsp_valid_q;
   assign host.rsp_rdata_o = rsp_rdata_q;
   assign host.busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed vector bench for spi_master_ctrl with an SPI slave model
module tb_spi_master_ctrl;
   import spi_pkg::*;

   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_GAP   = 4;
   localparam int LOW_LEN  = CS_SETUP + 64 * CLK_DIV + CS_HOLD;
   localparam int LATENCY  = LOW_LEN + 1;
   localparam int FRAME_LEN = LATENCY + CS_GAP;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] srd;
      logic [31:0] frame;
      logic [15:0] rdata;
   } vec_t;

   vec_t vecs[6];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   spi_master_ctrl_if hif();
   spi_master_ctrl_if fif();

   logic csb, sclk, sdo;
   logic sdi = 1'b0;
   logic f_csb, f_sclk, f_sdo, f_sdi;
   assign f_sdi = 1'b0;

   spi_master_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut (
      .spi_refclk_i (clk),
      .spi_resetn_i (rst_n),
      .host         (hif),
      .spi_csb_o    (csb),
      .spi_clk_o    (sclk),
      .spi_sdo_o    (sdo),
      .spi_sdi_i    (sdi)
   );

   spi_master_ctrl #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) u_fast (
      .spi_refclk_i (clk),
      .spi_resetn_i (rst_n),
      .host         (fif),
      .spi_csb_o    (f_csb),
      .spi_clk_o    (f_sclk),
      .spi_sdo_o    (f_sdo),
      .spi_sdi_i    (f_sdi)
   );

   // Slave model: samples mosi on sclk rise, drives read data on sclk fall
   logic [31:0] sh_in = '0;
   logic [15:0] slv_rdata = '0;
   int          rise_cnt = 0;
   logic [31:0] frames[$];
   int          rises[$];

   always @(posedge sclk or negedge csb) begin
      if (sclk) begin
         sh_in    <= {sh_in[30:0], sdo};
         rise_cnt <= rise_cnt + 1;
      end else begin
         rise_cnt <= 0;
      end
   end

   always @(negedge sclk) begin
      if (rise_cnt >= 16 && rise_cnt < 32) sdi <= slv_rdata[4'(31 - rise_cnt)];
      else sdi <= 1'b0;
   end

   always @(posedge csb) begin
      frames.push_back(sh_in);
      rises.push_back(rise_cnt);
   end

   int f_rises = 0;
   always @(posedge f_sclk) f_rises <= f_rises + 1;

   int          rsp_cnt = 0;
   int          rsp_cyc = 0;
   int          low_run = 0;
   int          high_run = 0;
   int          last_low = 0;
   int          last_gap = 0;
   logic        prev_csb = 1'b1;
   logic [15:0] rsp_q[$];

   always @(negedge clk) begin
      if (hif.rsp_valid_o === 1'b1) begin
         rsp_cnt++;
         rsp_cyc = cyc;
         rsp_q.push_back(hif.rsp_rdata_o);
      end
      if (csb === 1'b0) begin
         if (prev_csb) last_gap = high_run;
         low_run++;
         high_run = 0;
         prev_csb = 1'b0;
      end else begin
         if (!prev_csb) last_low = low_run;
         high_run++;
         low_run = 0;
         prev_csb = 1'b1;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] frame_at(input int i);
      if (i < frames.size()) return frames[i];
      return 'x;
   endfunction

   function automatic logic [31:0] rsp_at(input int i);
      if (i < rsp_q.size()) return 32'(rsp_q[i]);
      return 'x;
   endfunction

   task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input logic hold, output int acc);
      hif.req_write_i = w;
      hif.req_addr_i  = a;
      hif.req_wdata_i = d;
      hif.req_valid_i = 1'b1;
      acc = -1;
      for (int n = 0; n < 400 && acc < 0; n++) begin
         if (hif.req_ready_o) acc = cyc;
         tick();
      end
      if (!hold) hif.req_valid_i = 1'b0;
      check("accept_seen", 32'(acc >= 0), 32'd1);
   endtask

   task automatic wait_rsp(input int target, input string name);
      int n = 0;
      while (rsp_cnt < target && n < 1000) begin
         tick();
         n++;
      end
      check(name, 32'(rsp_cnt >= target), 32'd1);
   endtask

   initial begin
      int acc, acc2, base, bad_ready, f_low, f_high, f_rsp, f_pulses, f_r0;

      vecs[0] = '{1'b1, 8'h13, 16'h3456, 16'hFFFF, 32'h0113_3456, 16'h0000};
      vecs[1] = '{1'b0, 8'h20, 16'h0000, 16'hA5C3, 32'h0220_0000, 16'hA5C3};
      vecs[2] = '{1'b1, 8'hFF, 16'hFFFF, 16'h1234, 32'h01FF_FFFF, 16'h0000};
      vecs[3] = '{1'b0, 8'h00, 16'h0000, 16'h0001, 32'h0200_0000, 16'h0001};
      vecs[4] = '{1'b0, 8'h7E, 16'h0000, 16'h8000, 32'h027E_0000, 16'h8000};
      vecs[5] = '{1'b1, 8'h80, 16'h0001, 16'h0000, 32'h0180_0001, 16'h0000};

      hif.req_valid_i = 1'b0; hif.req_write_i = 1'b0; hif.req_addr_i = '0; hif.req_wdata_i = '0;
      fif.req_valid_i = 1'b0; fif.req_write_i = 1'b0; fif.req_addr_i = '0; fif.req_wdata_i = '0;

      repeat (3) tick();
      check("rst_csb", 32'(csb), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_ready", 32'(hif.req_ready_o), 32'd0);
      check("rst_rsp_valid", 32'(hif.rsp_valid_o), 32'd0);
      check("rst_rdata", 32'(hif.rsp_rdata_o), 32'd0);
      check("rst_busy", 32'(hif.busy_o), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      foreach (vecs[i]) begin
         frames.delete(); rises.delete(); rsp_q.delete();
         base = rsp_cnt;
         slv_rdata = vecs[i].srd;
         send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, acc);
         wait_rsp(base + 1, $sformatf("v%0d_rsp_seen", i));
         repeat (CS_GAP + 4) tick();
         check($sformatf("v%0d_frame", i), frame_at(0), vecs[i].frame);
         check($sformatf("v%0d_rises", i), (rises.size() > 0) ? 32'(rises[0]) : 'x, 32'd32);
         check($sformatf("v%0d_rsp_pulses", i), 32'(rsp_cnt - base), 32'd1);
         check($sformatf("v%0d_rdata", i), rsp_at(0), 32'(vecs[i].rdata));
         check($sformatf("v%0d_latency", i), 32'(rsp_cyc - acc), 32'(LATENCY));
         check($sformatf("v%0d_csb_low", i), 32'(last_low), 32'(LOW_LEN));
      end

      // CLK_DIV=1 timing on the second instance
      fif.req_write_i = 1'b1; fif.req_addr_i = 8'h13; fif.req_wdata_i = 16'h3456; fif.req_valid_i = 1'b1;
      acc = -1;
      f_r0 = f_rises;
      for (int n = 0; n < 20 && acc < 0; n++) begin
         if (fif.req_ready_o) acc = cyc;
         tick();
      end
      fif.req_valid_i = 1'b0;
      check("fast_accept_seen", 32'(acc >= 0), 32'd1);
      f_low = 0; f_high = 0; f_rsp = -1; f_pulses = 0;
      for (int n = 0; n < 150; n++) begin
         if (!f_csb) f_low++;
         if (f_sclk) f_high++;
         if (fif.rsp_valid_o) begin
            f_pulses++;
            if (f_rsp < 0) f_rsp = cyc - acc;
         end
         tick();
      end
      check("fast_csb_low", 32'(f_low), 32'd68);
      check("fast_latency", 32'(f_rsp), 32'd69);
      check("fast_rises", 32'(f_rises - f_r0), 32'd32);
      check("fast_sclk_high_cycles", 32'(f_high), 32'd32);
      check("fast_rsp_pulses", 32'(f_pulses), 32'd1);

      // Back-to-back writes, request fields disturbed while busy
      frames.delete(); rises.delete(); rsp_q.delete();
      base = rsp_cnt;
      slv_rdata = 16'h0F0F;
      send(1'b1, 8'h5A, 16'h1234, 1'b1, acc);
      hif.req_addr_i = 8'hA7; hif.req_wdata_i = 16'hCDEF;
      bad_ready = 0; acc2 = -1;
      for (int n = 0; n < 400 && acc2 < 0; n++) begin
         if (hif.busy_o && hif.req_ready_o) bad_ready++;
         if (hif.req_ready_o) acc2 = cyc;
         if (n == 40) begin hif.req_write_i = 1'b0; hif.req_addr_i = 8'hFF; hif.req_wdata_i = 16'hFFFF; end
         if (n == 90) begin hif.req_write_i = 1'b1; hif.req_addr_i = 8'hA7; hif.req_wdata_i = 16'hCDEF; end
         tick();
      end
      hif.req_valid_i = 1'b0;
      wait_rsp(base + 2, "b2b_rsp_seen");
      repeat (CS_GAP + 4) tick();
      check("b2b_ready_while_busy", 32'(bad_ready), 32'd0);
      check("b2b_second_accept", 32'(acc2 - acc), 32'(FRAME_LEN));
      check("b2b_frame0", frame_at(0), 32'h015A_1234);
      check("b2b_frame1", frame_at(1), 32'h01A7_CDEF);
      check("b2b_gap", 32'(last_gap), 32'(CS_GAP + 1));
      check("b2b_rsp_pulses", 32'(rsp_q.size()), 32'd2);
      check("b2b_rdata0", rsp_at(0), 32'h0);

      // Reset at the 10th sclk rise
      base = rsp_cnt;
      send(1'b1, 8'h33, 16'h7777, 1'b0, acc);
      for (int n = 0; n < 200 && rise_cnt != 10; n++) tick();
      check("rst_mid_reached_rise10", 32'(rise_cnt), 32'd10);
      rst_n = 1'b0;
      #1;
      check("rst_mid_csb", 32'(csb), 32'd1);
      check("rst_mid_sclk", 32'(sclk), 32'd0);
      check("rst_mid_sdo", 32'(sdo), 32'd0);
      check("rst_mid_busy", 32'(hif.busy_o), 32'd0);
      repeat (5) tick();
      rst_n = 1'b1;
      repeat (LATENCY) tick();
      check("rst_mid_no_rsp", 32'(rsp_cnt - base), 32'd0);

      frames.delete(); rises.delete(); rsp_q.delete();
      slv_rdata = 16'h5555;
      send(1'b1, 8'h44, 16'h9ABC, 1'b0, acc);
      wait_rsp(base + 1, "post_rst_rsp_seen");
      repeat (CS_GAP + 4) tick();
      check("post_rst_frame", frame_at(0), 32'h0144_9ABC);
      check("post_rst_rises", (rises.size() > 0) ? 32'(rises[0]) : 'x, 32'd32);
      check("post_rst_rdata", rsp_at(0), 32'h0);
      check("post_rst_pulses", 32'(rsp_cnt - base), 32'd1);
      check("post_rst_latency", 32'(rsp_cyc - acc), 32'(LATENCY));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
